// File: rtl/ccd_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ccd_frame_sequencer
//  Description : Sequences one CCD readout acquisition through the signal
//                generator's pad-level interface. Produces the generator
//                clock, raises enable, shifts the 4-bit frequency select in
//                MSB first under the load strobe, then counts frames on the
//                generator's phi_p output until the programmed frame count,
//                a watchdog timeout or an abort ends the run.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    wb_clk_i          in   single system clock
//    wb_rst_i          in   asynchronous active-high reset
//    start_i           in   one-cycle start request (ignored while busy)
//    abort_i           in   one-cycle abort request
//    cfg_freq_i        in   frequency select to shift into the generator
//    cfg_frames_i      in   frames to acquire (0 = complete immediately)
//    cfg_timeout_i     in   max wb_clk_i cycles between frames (0 = off)
//    phi_p_i           in   generator phi_p, asynchronous to wb_clk_i
//    gen_clk_o         out  generator clock, wb_clk_i / (2*CLK_DIV)
//    gen_enable_o      out  generator enable
//    gen_fsel_serial_o out  serial frequency-select data
//    gen_load_config_o out  serial load strobe
//    busy_o            out  high whenever the sequencer is not idle
//    done_o            out  one-cycle completion pulse
//    error_o           out  sticky watchdog error
//    frames_done_o     out  frames counted in this run
//    state_o           out  IDLE=0 ENABLE=1 LOAD=2 LATCH=3 RUN=4
// ============================================================================
module ccd_frame_sequencer #(
    parameter int CLK_DIV   = 4,
    parameter int FRAMES_W  = 16,
    parameter int TIMEOUT_W = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [3:0]           cfg_freq_i,
    input  logic [FRAMES_W-1:0]  cfg_frames_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    input  logic                 phi_p_i,
    output logic                 gen_clk_o,
    output logic                 gen_enable_o,
    output logic                 gen_fsel_serial_o,
    output logic                 gen_load_config_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [FRAMES_W-1:0]  frames_done_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENABLE = 3'd1,
        S_LOAD   = 3'd2,
        S_LATCH  = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------------
    // Generator clock divider. Free-running from reset; gen_clk toggles once
    // every CLK_DIV wb_clk_i cycles. gen_fall marks the cycle on which
    // gen_clk is driven low, and every generator-facing control output is
    // updated on that same edge so it is stable across the following rise.
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             gen_clk_q;
    logic             div_wrap;
    logic             gen_fall;

    assign div_wrap = (div_q == DIV_LAST);
    assign gen_fall = div_wrap & gen_clk_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_q     <= '0;
            gen_clk_q <= 1'b0;
        end else if (div_wrap) begin
            div_q     <= '0;
            gen_clk_q <= ~gen_clk_q;
        end else begin
            div_q     <= div_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // phi_p synchronizer: two metastability flops, a history flop and a
    // registered edge pulse. The pulse is qualified with RUN at detection
    // time so rises seen during configuration never reach the counter.
    // ------------------------------------------------------------------------
    state_t state_q;
    logic   phi_meta_q;
    logic   phi_sync_q;
    logic   phi_hist_q;
    logic   phi_edge_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            phi_meta_q <= 1'b0;
            phi_sync_q <= 1'b0;
            phi_hist_q <= 1'b0;
            phi_edge_q <= 1'b0;
        end else begin
            phi_meta_q <= phi_p_i;
            phi_sync_q <= phi_meta_q;
            phi_hist_q <= phi_sync_q;
            phi_edge_q <= phi_sync_q & ~phi_hist_q & (state_q == S_RUN);
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM and its registered outputs.
    // ------------------------------------------------------------------------
    logic                 enable_q;
    logic                 load_q;
    logic                 serial_q;
    logic                 done_q;
    logic                 error_q;
    logic [FRAMES_W-1:0]  frames_q;
    logic [FRAMES_W-1:0]  target_q;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [TIMEOUT_W-1:0] wd_q;
    logic [TIMEOUT_W-1:0] wd_d;
    logic [3:0]           shift_q;   // frequency select, consumed MSB first
    logic [1:0]           bits_q;    // bits already followed by freq[3]

    assign wd_d = wd_q + TIMEOUT_W'(1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            enable_q  <= 1'b0;
            load_q    <= 1'b0;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            frames_q  <= '0;
            target_q  <= '0;
            timeout_q <= '0;
            wd_q      <= '0;
            shift_q   <= '0;
            bits_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && (state_q != S_IDLE)) begin
                // Abort wins over everything; the frame count and the error
                // flag are deliberately left as they are.
                state_q  <= S_IDLE;
                enable_q <= 1'b0;
                load_q   <= 1'b0;
                serial_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            if (cfg_frames_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                shift_q   <= cfg_freq_i;
                                target_q  <= cfg_frames_i;
                                timeout_q <= cfg_timeout_i;
                                frames_q  <= '0;
                                error_q   <= 1'b0;
                                state_q   <= S_ENABLE;
                            end
                        end
                    end

                    S_ENABLE: begin
                        // First falling tick raises enable, second one opens
                        // the load window with the MSB already on the line.
                        if (gen_fall) begin
                            if (!enable_q) begin
                                enable_q <= 1'b1;
                            end else begin
                                load_q   <= 1'b1;
                                serial_q <= shift_q[3];
                                shift_q  <= {shift_q[2:0], 1'b0};
                                bits_q   <= '0;
                                state_q  <= S_LOAD;
                            end
                        end
                    end

                    S_LOAD: begin
                        if (gen_fall) begin
                            if (bits_q == 2'd3) begin
                                load_q   <= 1'b0;
                                serial_q <= 1'b0;
                                state_q  <= S_LATCH;
                            end else begin
                                serial_q <= shift_q[3];
                                shift_q  <= {shift_q[2:0], 1'b0};
                                bits_q   <= bits_q + 2'd1;
                            end
                        end
                    end

                    S_LATCH: begin
                        // One full generator period so the generator sees its
                        // latch edge before frames are counted.
                        if (gen_fall) begin
                            wd_q    <= '0;
                            state_q <= S_RUN;
                        end
                    end

                    S_RUN: begin
                        if (frames_q == target_q) begin
                            enable_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_IDLE;
                        end else if (phi_edge_q) begin
                            // An edge outranks a coincident timeout.
                            frames_q <= frames_q + FRAMES_W'(1);
                            wd_q     <= '0;
                        end else if ((timeout_q != '0) && (wd_d == timeout_q)) begin
                            error_q  <= 1'b1;
                            enable_q <= 1'b0;
                            state_q  <= S_IDLE;
                        end else begin
                            wd_q <= wd_d;
                        end
                    end

                    default: begin
                        state_q  <= S_IDLE;
                        enable_q <= 1'b0;
                        load_q   <= 1'b0;
                        serial_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign gen_clk_o         = gen_clk_q;
    assign gen_enable_o      = enable_q;
    assign gen_fsel_serial_o = serial_q;
    assign gen_load_config_o = load_q;
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = done_q;
    assign error_o           = error_q;
    assign frames_done_o     = frames_q;
    assign state_o           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ccd_frame_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ccd_frame_sequencer
//  Description : Self-checking bench for ccd_frame_sequencer: a table of
//                complete acquisitions plus directed multi-cycle sequences
//                (phi_p latency, watchdog distance, abort, zero frames,
//                ignored restart, asynchronous reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_frame_sequencer;

    localparam int CLK_DIV   = 4;
    localparam int FRAMES_W  = 16;
    localparam int TIMEOUT_W = 32;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [3:0]           freq  = '0;
    logic [FRAMES_W-1:0]  nfr   = '0;
    logic [TIMEOUT_W-1:0] tmo   = '0;
    logic                 phi   = 1'b0;

    logic                gen_clk, gen_en, gen_ser, gen_load, busy, done, err;
    logic [FRAMES_W-1:0] frames_done;
    logic [2:0]          state;

    ccd_frame_sequencer #(
        .CLK_DIV   (CLK_DIV),
        .FRAMES_W  (FRAMES_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .start_i           (start),
        .abort_i           (abort),
        .cfg_freq_i        (freq),
        .cfg_frames_i      (nfr),
        .cfg_timeout_i     (tmo),
        .phi_p_i           (phi),
        .gen_clk_o         (gen_clk),
        .gen_enable_o      (gen_en),
        .gen_fsel_serial_o (gen_ser),
        .gen_load_config_o (gen_load),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (err),
        .frames_done_o     (frames_done),
        .state_o           (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Generator model: shifts in serial data on gen_clk rises while load high.
    logic [3:0] cap   = '0;
    int         cap_n = 0;
    always @(posedge gen_clk) begin
        if (gen_load) begin
            cap = {cap[2:0], gen_ser};
            cap_n++;
        end
    end

    // Running event counters/timestamps; tests take deltas of these.
    int done_cnt = 0, en_hi = 0, t_en = 0, t_load = 0, t_inc = 0, t_done = 0;
    int t_gr = 0, t_gr_prev = 0, gr_cnt = 0;
    logic                prev_en = 1'b0, prev_load = 1'b0, prev_gclk = 1'b0;
    logic [FRAMES_W-1:0] prev_fr = '0;
    always @(negedge clk) begin
        if (done) begin done_cnt++; t_done = cyc; end
        if (gen_en) en_hi++;
        if (gen_en && !prev_en) t_en = cyc;
        if (gen_load && !prev_load) t_load = cyc;
        if (frames_done != prev_fr) t_inc = cyc;
        if (gen_clk && !prev_gclk) begin t_gr_prev = t_gr; t_gr = cyc; gr_cnt++; end
        prev_en = gen_en; prev_load = gen_load; prev_gclk = gen_clk; prev_fr = frames_done;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic do_start(input logic [3:0] f, input int unsigned n, input int unsigned t);
        @(negedge clk);
        freq  = f;
        nfr   = n[FRAMES_W-1:0];
        tmo   = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int i = 0;
        while (state !== s && i < budget) begin @(negedge clk); i++; end
        check(name, {29'd0, state}, {29'd0, s});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i = 0;
        while (busy !== 1'b0 && i < budget) begin @(negedge clk); i++; end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic phi_pulse();
        phi = 1'b1;
        repeat (6) @(negedge clk);
        phi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  freq;
        int unsigned frames;
        int unsigned tmo;
        int          pulses;
        int          exp_done;
        logic        exp_err;
        int unsigned exp_frames;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cn0, dn0, e0, t1, t2, i;

        //            freq     frm tmo  pls done err frames
        vecs[0] = '{4'b1010, 3,  0,   3,  1,   1'b0, 3};
        vecs[1] = '{4'b0101, 1,  0,   1,  1,   1'b0, 1};
        vecs[2] = '{4'b1111, 2,  100, 1,  0,   1'b1, 1};
        vecs[3] = '{4'b1100, 4,  50,  4,  1,   1'b0, 4};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("reset outputs",
              {6'd0, gen_clk, gen_en, gen_ser, gen_load, busy, done, err, frames_done, state}, 32'd0);
        rst = 1'b0;

        // gen_clk period = 2*CLK_DIV cycles
        i = 0;
        while (gr_cnt < 3 && i < 100) begin @(negedge clk); i++; end
        check("gen_clk period", t_gr - t_gr_prev, 2 * CLK_DIV);

        // ---------------- table of complete acquisitions ----------------
        for (int k = 0; k < 4; k++) begin
            cn0 = cap_n;
            dn0 = done_cnt;
            do_start(vecs[k].freq, vecs[k].frames, vecs[k].tmo);
            wait_state(3'd4, 300, "reach RUN");
            for (int p = 0; p < vecs[k].pulses; p++) phi_pulse();
            wait_idle(600, "return to IDLE");
            repeat (4) @(negedge clk);
            check("serial bits", {28'd0, cap}, {28'd0, vecs[k].freq});
            check("load rises", cap_n - cn0, 4);
            check("done pulses", done_cnt - dn0, vecs[k].exp_done);
            check("error flag", {31'd0, err}, {31'd0, vecs[k].exp_err});
            check("frames done", {16'd0, frames_done}, vecs[k].exp_frames);
            check("enable low after", {31'd0, gen_en}, 32'd0);
            check("enable to load", t_load - t_en, 2 * CLK_DIV);
            if (vecs[k].exp_done != 0) check("done latency", t_done - t_inc, 1);
        end

        // ---------------- phi_p latency and exact watchdog distance ----------------
        dn0 = done_cnt;
        do_start(4'b0001, 2, 100);
        wait_state(3'd4, 300, "wd reach RUN");
        phi = 1'b1;
        repeat (3) @(negedge clk);
        check("phi latency early", {16'd0, frames_done}, 32'd0);
        @(negedge clk);
        check("phi latency 3 edges", {16'd0, frames_done}, 32'd1);
        t1 = cyc;
        phi = 1'b0;
        i = 0;
        while (err !== 1'b1 && i < 300) begin @(negedge clk); i++; end
        t2 = cyc;
        check("watchdog fired", {31'd0, err}, 32'd1);
        check("watchdog distance", t2 - t1, 100);
        check("watchdog enable low", {31'd0, gen_en}, 32'd0);
        check("watchdog no done", done_cnt - dn0, 0);

        // ---------------- abort during LOAD after 2 bits ----------------
        cn0 = cap_n;
        dn0 = done_cnt;
        do_start(4'b0110, 1, 0);
        i = 0;
        while ((cap_n - cn0) < 2 && i < 300) begin @(negedge clk); i++; end
        check("abort bits before", cap_n - cn0, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort state", {29'd0, state}, 32'd0);
        check("abort load/en/ser", {29'd0, gen_load, gen_en, gen_ser}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort no done", done_cnt - dn0, 0);
        cn0 = cap_n;
        do_start(4'b1010, 1, 0);
        wait_state(3'd4, 300, "restart reach RUN");
        phi_pulse();
        wait_idle(300, "restart IDLE");
        check("restart bits", {28'd0, cap}, 32'b1010);
        check("restart load rises", cap_n - cn0, 4);

        // ---------------- start with zero frames ----------------
        dn0 = done_cnt;
        e0  = en_hi;
        @(negedge clk);
        nfr   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero frames done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("zero frames done pulse", {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        check("zero frames no enable", en_hi - e0, 0);
        check("zero frames idle", {29'd0, state}, 32'd0);

        // ---------------- phi_p before RUN, start during RUN ----------------
        dn0 = done_cnt;
        do_start(4'b0110, 2, 0);
        i = 0;
        while (state !== 3'd3 && state !== 3'd4 && i < 300) begin
            if (i % 3 == 0) phi = ~phi;
            @(negedge clk);
            i++;
        end
        phi = 1'b0;
        wait_state(3'd4, 100, "noise reach RUN");
        repeat (5) @(negedge clk);
        check("no count before RUN", {16'd0, frames_done}, 32'd0);
        @(negedge clk);
        freq  = 4'b1111;
        nfr   = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start ignored in RUN", {29'd0, state}, 32'd4);
        phi_pulse();
        phi_pulse();
        wait_idle(300, "ignored start IDLE");
        check("ignored start frames", {16'd0, frames_done}, 32'd2);
        check("ignored start done", done_cnt - dn0, 1);

        // ---------------- asynchronous reset mid-RUN ----------------
        do_start(4'b0011, 3, 0);
        wait_state(3'd4, 300, "rst reach RUN");
        phi_pulse();
        check("enable before reset", {31'd0, gen_en}, 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async reset outputs",
              {6'd0, gen_clk, gen_en, gen_ser, gen_load, busy, done, err, frames_done, state}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dn0 = done_cnt;
        do_start(4'b1001, 2, 0);
        wait_state(3'd4, 300, "post-reset reach RUN");
        phi_pulse();
        phi_pulse();
        wait_idle(300, "post-reset IDLE");
        check("post-reset bits", {28'd0, cap}, 32'b1001);
        check("post-reset frames", {16'd0, frames_done}, 32'd2);
        check("post-reset done", done_cnt - dn0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
